ili9341_spi_tx: RTL and testbench

Byte-wide SPI transmitter (mode 0, MSB first) driving the ILI9341 panel's CS/SCK/MOSI/D-C pins. It derives SCK internally by dividing `i_clk` with a half-period counter, so it needs no separate divided clock. Upstream command/pixel sequencers feed it bytes through a valid/ready handshake. Back-to-back bytes are sent as one CS-low burst.

---
 rtl/ili9341_spi_tx.sv | 172 +++++++++++++++++
 tb/tb_ili9341_spi_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_spi_tx.sv
// ----------------------------------------------------------------------------
// ili9341_spi_tx
// Byte-wide SPI mode-0 transmitter (MSB first) for the ILI9341 panel.
// SCK is generated from i_clk by a half-period counter, so the block runs
// entirely in the i_clk domain. Bytes arrive over a valid/ready handshake.
// A byte accepted while the previous one is in its post-byte HOLD window
// continues the same CS-low burst.
//
// Parameters
//   HALF_DIV : i_clk cycles per SCK half-period (>= 1)
//   CNT_W    : width of the half-period counter
// Ports
//   i_clk    : system clock
//   rst      : asynchronous reset, active low
//   i_data   : byte to send, sampled at the acceptance edge
//   i_dc     : D/C level for the byte (0 = command, 1 = data)
//   i_valid  : byte offered
//   o_ready  : byte can be accepted this cycle (combinational)
//   o_done   : one-cycle pulse on the last SCK falling edge of a byte
//   o_cs_n   : panel chip select, active low
//   o_sck    : SPI clock, idle low
//   o_mosi   : serial data
//   o_dc     : registered D/C line
// ----------------------------------------------------------------------------
module ili9341_spi_tx #(
  parameter int HALF_DIV = 2,
  parameter int CNT_W    = $clog2(HALF_DIV) + 1
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_dc,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_cs_n,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_dc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HALF_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] half_r, half_s;
  logic [2:0]       bit_r, bit_s;
  // Holds the bits still to be sent below the one currently on MOSI.
  logic [6:0]       shreg_r, shreg_s;
  logic             cs_n_r, cs_n_s;
  logic             sck_r, sck_s;
  logic             mosi_r, mosi_s;
  logic             dc_r, dc_s;
  logic             done_r, done_s;
  logic             accept_s;
  logic             half_wrap_s;

  assign o_ready     = rst & ((state_r == IDLE) | (state_r == HOLD));
  assign accept_s    = i_valid & o_ready;
  assign half_wrap_s = (half_r == HALF_LAST);

  assign o_done = done_r;
  assign o_cs_n = cs_n_r;
  assign o_sck  = sck_r;
  assign o_mosi = mosi_r;
  assign o_dc   = dc_r;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_s = state_r;
    half_s  = half_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    cs_n_s  = cs_n_r;
    sck_s   = sck_r;
    mosi_s  = mosi_r;
    dc_s    = dc_r;
    done_s  = 1'b0;
    if (accept_s) begin
      // Accept only happens in IDLE or HOLD, where SCK is already low,
      // so reloading MOSI and D/C here never disturbs a high SCK phase.
      state_s = SHIFT;
      half_s  = HALF_ZERO;
      bit_s   = 3'd7;
      shreg_s = i_data[6:0];
      cs_n_s  = 1'b0;
      sck_s   = 1'b0;
      mosi_s  = i_data[7];
      dc_s    = i_dc;
    end else begin
      case (state_r)
        IDLE: begin
          cs_n_s = 1'b1;
          sck_s  = 1'b0;
          half_s = HALF_ZERO;
        end
        SHIFT: begin
          if (half_wrap_s) begin
            half_s = HALF_ZERO;
            if (!sck_r) begin
              sck_s = 1'b1;
            end else begin
              sck_s = 1'b0;
              if (bit_r != 3'd0) begin
                bit_s   = bit_r - 3'd1;
                mosi_s  = shreg_r[6];
                shreg_s = {shreg_r[5:0], 1'b0};
              end else begin
                done_s  = 1'b1;
                state_s = HOLD;
              end
            end
          end else begin
            half_s = half_r + HALF_ONE;
          end
        end
        HOLD: begin
          // CS stays low for one more half-period so a follow-on byte
          // can join the burst.
          sck_s = 1'b0;
          if (half_wrap_s) begin
            state_s = IDLE;
            cs_n_s  = 1'b1;
            half_s  = HALF_ZERO;
          end else begin
            half_s = half_r + HALF_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          half_s  = HALF_ZERO;
          bit_s   = 3'd0;
          cs_n_s  = 1'b1;
          sck_s   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      half_r  <= HALF_ZERO;
      bit_r   <= 3'd0;
      shreg_r <= 7'd0;
      cs_n_r  <= 1'b1;
      sck_r   <= 1'b0;
      mosi_r  <= 1'b0;
      dc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      half_r  <= half_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      cs_n_r  <= cs_n_s;
      sck_r   <= sck_s;
      mosi_r  <= mosi_s;
      dc_r    <= dc_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// ----------------------------------------------------------------------------
// tb_ili9341_spi_tx
// Self-checking bench for ili9341_spi_tx. Two instances are exercised:
// DUT A with HALF_DIV=2 and DUT B with HALF_DIV=1. A cycle-level reference
// model predicts every output from the time elapsed since the last accepted
// byte; a table of single-byte transfers plus hand-written burst, busy and
// reset sequences and a randomized phase drive the instances.
// ----------------------------------------------------------------------------
module tb_ili9341_spi_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_data, b_data;
  logic       a_dc_i, b_dc_i, a_valid, b_valid;
  logic       a_ready, a_done, a_cs_n, a_sck, a_mosi, a_dc;
  logic       b_ready, b_done, b_cs_n, b_sck, b_mosi, b_dc;

  ili9341_spi_tx #(.HALF_DIV(2)) u_dut_a (
    .i_clk(clk), .rst(rst), .i_data(a_data), .i_dc(a_dc_i), .i_valid(a_valid),
    .o_ready(a_ready), .o_done(a_done), .o_cs_n(a_cs_n), .o_sck(a_sck),
    .o_mosi(a_mosi), .o_dc(a_dc)
  );

  ili9341_spi_tx #(.HALF_DIV(1)) u_dut_b (
    .i_clk(clk), .rst(rst), .i_data(b_data), .i_dc(b_dc_i), .i_valid(b_valid),
    .o_ready(b_ready), .o_done(b_done), .o_cs_n(b_cs_n), .o_sck(b_sck),
    .o_mosi(b_mosi), .o_dc(b_dc)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state, per instance
  int         hdiv[2];
  bit         have[2];
  int         last_acc[2];
  logic [7:0] mbyte[2];
  logic       mdc[2];
  bit         acc_flag[2];

  // Observed outputs and bus monitor state
  logic       o_rdy[2], o_dn[2], o_cs[2], o_sk[2], o_mo[2], o_dcv[2];
  logic       prev_sck[2], prev_dc[2];
  logic [7:0] cap[2];
  int         capn[2];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       dc;
    int         len;
    int         done_off;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [7:0] d, input logic dv);
    if (s == 0) begin
      a_valid = v; a_data = d; a_dc_i = dv;
    end else begin
      b_valid = v; b_data = d; b_dc_i = dv;
    end
  endtask

  function automatic logic exp_ready(input int s);
    return rst && (!have[s] || ((cyc - last_acc[s]) >= 16 * hdiv[s]));
  endfunction

  task automatic gather();
    o_rdy[0] = a_ready; o_dn[0] = a_done; o_cs[0] = a_cs_n;
    o_sk[0]  = a_sck;   o_mo[0] = a_mosi; o_dcv[0] = a_dc;
    o_rdy[1] = b_ready; o_dn[1] = b_done; o_cs[1] = b_cs_n;
    o_sk[1]  = b_sck;   o_mo[1] = b_mosi; o_dcv[1] = b_dc;
  endtask

  // Expected outputs as a function of p = cycles since the last acceptance:
  // CS low for 17H, SCK high in odd half-periods of the first 16H cycles,
  // MOSI shows bit 7-p/(2H), done exactly at p = 16H.
  task automatic model_check(input int s);
    int   p, h;
    logic e_cs, e_sck, e_mo, e_done, e_dc;
    h = hdiv[s];
    p = cyc - last_acc[s];
    if (!have[s]) begin
      e_cs = 1'b1; e_sck = 1'b0; e_mo = 1'b0; e_done = 1'b0; e_dc = 1'b0;
    end else begin
      e_cs   = (p < 17 * h) ? 1'b0 : 1'b1;
      e_sck  = (p < 16 * h) ? (((p / h) % 2) == 1) : 1'b0;
      e_mo   = (p < 16 * h) ? mbyte[s][7 - p / (2 * h)] : mbyte[s][0];
      e_done = (p == 16 * h);
      e_dc   = mdc[s];
    end
    chk(s == 0 ? "a_cs_n" : "b_cs_n", o_cs[s], e_cs);
    chk(s == 0 ? "a_sck" : "b_sck", o_sk[s], e_sck);
    chk(s == 0 ? "a_mosi" : "b_mosi", o_mo[s], e_mo);
    chk(s == 0 ? "a_done" : "b_done", o_dn[s], e_done);
    chk(s == 0 ? "a_dc" : "b_dc", o_dcv[s], e_dc);
    chk(s == 0 ? "a_ready" : "b_ready", o_rdy[s], exp_ready(s));
    if (o_sk[s] === 1'b1 && prev_sck[s] === 1'b0) begin
      cap[s] = {cap[s][6:0], o_mo[s]};
      capn[s]++;
    end
    if (o_dcv[s] !== prev_dc[s])
      chk("dc_change_while_sck_low", {30'd0, prev_sck[s], o_sk[s]}, 32'd0);
    prev_sck[s] = o_sk[s];
    prev_dc[s]  = o_dcv[s];
  endtask

  // One clock: decide acceptances from the model, advance, sample at +1.
  task automatic step();
    acc_flag[0] = (a_valid === 1'b1) && exp_ready(0);
    acc_flag[1] = (b_valid === 1'b1) && exp_ready(1);
    @(posedge clk);
    cyc++;
    if (acc_flag[0]) begin have[0] = 1; last_acc[0] = cyc; mbyte[0] = a_data; mdc[0] = a_dc_i; end
    if (acc_flag[1]) begin have[1] = 1; last_acc[1] = cyc; mbyte[1] = b_data; mdc[1] = b_dc_i; end
    #1;
    gather();
    model_check(0);
    model_check(1);
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    have[0] = 0; have[1] = 0;
    #1;
    gather();
    chk("rst_async_cs_n", o_cs[0], 1);
    chk("rst_async_sck", o_sk[0], 0);
    for (int s = 0; s < 2; s++) begin
      prev_sck[s] = o_sk[s];
      prev_dc[s]  = o_dcv[s];
      cap[s]      = 8'd0;
      capn[s]     = 0;
    end
    model_check(0);
    model_check(1);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    #1;
    gather();
    model_check(0);
    model_check(1);
  endtask

  // Single byte: measure CS-low length, done offset, bit stream.
  task automatic run_one(input int s, input logic [7:0] d, input logic dv,
                         input int exp_len, input int exp_done, input bit inject_busy);
    int fall, rise, dcyc, nd, inj_at;
    fall = -1; rise = -1; dcyc = -1; nd = 0; inj_at = -1;
    cap[s] = 8'd0; capn[s] = 0;
    set_in(s, 1'b1, d, dv);
    for (int i = 0; i < 200 && rise < 0; i++) begin
      step();
      if (acc_flag[s]) begin
        set_in(s, 1'b0, 8'h00, 1'b0);
        if (inject_busy) inj_at = cyc + 6;
      end
      if (cyc == inj_at) begin
        chk("busy_ready_low", o_rdy[s], 0);
        set_in(s, 1'b1, 8'hFF, 1'b1);
      end else if (inj_at >= 0 && cyc == inj_at + 1) begin
        set_in(s, 1'b0, 8'h00, 1'b0);
      end
      if (fall < 0 && o_cs[s] === 1'b0) fall = cyc;
      if (o_dn[s] === 1'b1) begin nd++; dcyc = cyc; end
      if (fall >= 0 && o_cs[s] === 1'b1) rise = cyc;
    end
    chk("cs_low_len", rise - fall, exp_len);
    chk("done_offset", dcyc - fall, exp_done);
    chk("done_count", nd, 1);
    chk("bit_count", capn[s], 8);
    chk("bit_stream", cap[s], d);
  endtask

  task automatic burst();
    logic [7:0] bd[3];
    logic       bdc[3];
    int         acc_c[3];
    int         k, nb, highs, rise;
    bd[0] = 8'h2C; bd[1] = 8'hA5; bd[2] = 8'h5A;
    bdc[0] = 1'b0; bdc[1] = 1'b1; bdc[2] = 1'b1;
    acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
    k = 0; nb = 0; highs = 0; rise = -1;
    cap[0] = 8'd0; capn[0] = 0;
    set_in(0, 1'b1, bd[0], bdc[0]);
    for (int i = 0; i < 300 && rise < 0; i++) begin
      step();
      if (acc_flag[0]) begin
        acc_c[k] = cyc;
        k++;
        if (k < 3) set_in(0, 1'b1, bd[k], bdc[k]);
        else set_in(0, 1'b0, 8'h00, 1'b0);
      end
      if (capn[0] == 8) begin
        if (nb < 3) chk("burst_byte", cap[0], bd[nb]);
        else chk("burst_byte_count", nb + 1, 3);
        nb++;
        capn[0] = 0;
      end
      if (k > 0 && o_cs[0] === 1'b1) begin
        if (k == 3) rise = cyc;
        else highs++;
      end
    end
    chk("burst_cs_gaps", highs, 0);
    chk("burst_period_1", acc_c[1] - acc_c[0], 33);
    chk("burst_period_2", acc_c[2] - acc_c[1], 33);
    chk("burst_cs_total", rise - acc_c[0], 100);
    chk("burst_bytes", nb, 3);
  endtask

  initial begin
    hdiv[0] = 2; hdiv[1] = 1;
    for (int s = 0; s < 2; s++) begin
      have[s] = 0; last_acc[s] = 0; mbyte[s] = 8'd0; mdc[s] = 1'b0;
      prev_sck[s] = 1'b0; prev_dc[s] = 1'b0; cap[s] = 8'd0; capn[s] = 0;
      set_in(s, 1'b0, 8'h00, 1'b0);
    end
    tbl[0] = '{0, 8'h2A, 1'b0, 34, 32};
    tbl[1] = '{0, 8'hC3, 1'b1, 34, 32};
    tbl[2] = '{0, 8'h00, 1'b1, 34, 32};
    tbl[3] = '{1, 8'h80, 1'b0, 17, 16};
    tbl[4] = '{1, 8'h5F, 1'b1, 17, 16};
    tbl[5] = '{1, 8'hFF, 1'b0, 17, 16};

    rst = 1'b1;
    #1;
    assert_reset();
    repeat (3) step();
    release_reset();

    for (int i = 0; i < 6; i++)
      run_one(tbl[i].sel, tbl[i].data, tbl[i].dc, tbl[i].len, tbl[i].done_off, 1'b0);

    run_one(0, 8'h3C, 1'b0, 34, 32, 1'b1);
    repeat (3) step();

    burst();
    repeat (3) step();

    // Reset in the middle of 0xF0, after its third SCK rise
    cap[0] = 8'd0; capn[0] = 0;
    set_in(0, 1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 100 && capn[0] < 3; i++) begin
      step();
      if (acc_flag[0]) set_in(0, 1'b0, 8'h00, 1'b0);
    end
    chk("rst_mid_rise3_reached", capn[0], 3);
    set_in(0, 1'b0, 8'h00, 1'b0);
    assert_reset();
    repeat (2) step();
    release_reset();
    run_one(0, 8'h81, 1'b0, 34, 32, 1'b0);

    // Randomized traffic on both instances
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) set_in(0, 1'b1, 8'($urandom), 1'($urandom));
      else set_in(0, 1'b0, 8'h00, 1'b0);
      if ($urandom_range(0, 2) == 0) set_in(1, 1'b1, 8'($urandom), 1'($urandom));
      else set_in(1, 1'b0, 8'h00, 1'b0);
      step();
    end
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    repeat (60) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
